// File: rtl/hub_slot_arb.sv
// hub_slot_arb: shares the single hub memory port among NCOGS cogs.
// Each qualifying bus cycle at most one eligible cog is granted. Its
// operands are driven onto the hub_mem port, and its ack pulses one clock
// later together with the returned read word.
module hub_slot_arb #(
  parameter int NCOGS      = 8,
  parameter int AW         = 14,
  parameter int FIXED_SLOT = 1
) (
  input  logic                       clk_cog,
  input  logic                       res,
  input  logic                       ena_bus,
  input  logic [NCOGS-1:0]           req,
  input  logic [NCOGS-1:0]           w,
  input  logic [4*NCOGS-1:0]         wb,
  input  logic [AW*NCOGS-1:0]        a,
  input  logic [32*NCOGS-1:0]        d,
  output logic [NCOGS-1:0]           ack,
  output logic [31:0]                q,
  output logic [$clog2(NCOGS)-1:0]   slot,
  output logic                       mem_ena,
  output logic                       mem_w,
  output logic [3:0]                 mem_wb,
  output logic [AW-1:0]              mem_a,
  output logic [31:0]                mem_d,
  input  logic [31:0]                mem_q
);

  localparam int SW = $clog2(NCOGS);
  localparam logic [SW-1:0] PTR_ONE = SW'(1);

  // Slot pointer and the grant issued on the previous edge (ack source).
  logic [SW-1:0]    ptr_q;
  logic [SW-1:0]    ptr_d;
  logic [NCOGS-1:0] ack_pend_q;

  logic [NCOGS-1:0] elig_s;
  logic [NCOGS-1:0] gnt_s;
  logic [SW-1:0]    gidx_s;
  logic [SW-1:0]    cand_s;
  logic             found_s;

  // A cog whose ack is showing this cycle sits out one arbitration round.
  assign elig_s = req & ~ack_pend_q;

  // Grant selection: strict rotating slot, or first eligible at/after ptr.
  always_comb begin
    gnt_s   = '0;
    gidx_s  = '0;
    cand_s  = '0;
    found_s = 1'b0;
    if (ena_bus && !res) begin
      if (FIXED_SLOT != 0) begin
        if (elig_s[ptr_q]) begin
          gnt_s[ptr_q] = 1'b1;
          gidx_s       = ptr_q;
          found_s      = 1'b1;
        end else begin
          gnt_s = '0;
        end
      end else begin
        for (int i = 0; i < NCOGS; i++) begin
          // NCOGS is a power of two, so the wrap is a plain truncation.
          cand_s = ptr_q + SW'(i);
          if (!found_s && elig_s[cand_s]) begin
            gnt_s[cand_s] = 1'b1;
            gidx_s        = cand_s;
            found_s       = 1'b1;
          end else begin
            found_s = found_s;
          end
        end
      end
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer advance: every bus cycle in slot mode, past the winner otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (ena_bus) begin
      if (FIXED_SLOT != 0) begin
        ptr_d = ptr_q + PTR_ONE;
      end else if (found_s) begin
        ptr_d = gidx_s + PTR_ONE;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; the pending ack is simply last cycle's grant.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      ptr_q      <= '0;
      ack_pend_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ack_pend_q <= gnt_s;
    end
  end

  // Operand mux: grant is one-hot, so an AND-OR tree selects the winner.
  always_comb begin
    mem_w  = 1'b0;
    mem_wb = 4'h0;
    mem_a  = '0;
    mem_d  = 32'h0;
    for (int k = 0; k < NCOGS; k++) begin
      mem_w  = mem_w  | (w[k] & gnt_s[k]);
      mem_wb = mem_wb | (wb[4*k +: 4] & {4{gnt_s[k]}});
      mem_a  = mem_a  | (a[AW*k +: AW] & {AW{gnt_s[k]}});
      mem_d  = mem_d  | (d[32*k +: 32] & {32{gnt_s[k]}});
    end
  end

  assign mem_ena = |gnt_s;
  assign slot    = ptr_q;

  // Reset arriving on the ack cycle drops the ack; the access is lost.
  assign ack = ack_pend_q & {NCOGS{~res}};
  assign q   = (|ack) ? mem_q : 32'h0;

endmodule
